// File: rtl/word_serializer_pkg.sv
// Shared definitions for the serial operand bus transmitter and its receiver-side controller.
package word_serializer_pkg;

  // Two-state transfer controller: waiting for a word, or shifting one out.
  typedef enum logic [0:0] {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  // Bit counter width able to hold the value SIZE itself (counts SIZE down to 1).
  function automatic int unsigned cnt_width(input int unsigned size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial transmitter: accepts a SIZE-bit word on a valid/ready handshake and
// shifts it out MSB-first with one sen strobe per bit. A stall freezes all progress.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int unsigned SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_valid,
  input  logic [SIZE-1:0] load_data,
  output logic            load_ready,
  input  logic            stall,
  output logic            sd,
  output logic            sen,
  output logic            done
);

  localparam int unsigned     CntW    = cnt_width(SIZE);
  localparam logic [CntW-1:0] CntInit = CntW'(SIZE);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  state_e            state_q, state_d;
  logic [SIZE-1:0]   shreg_q, shreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;

  // Next-state and output decode; sd/sen stay combinational so stall acts in the same cycle.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    load_ready = 1'b0;
    sen        = 1'b0;
    sd         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          shreg_d = load_data;
          cnt_d   = CntInit;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        sen = ~stall;
        if (!stall) begin
          sd      = shreg_q[SIZE-1];
          shreg_d = {shreg_q[SIZE-2:0], 1'b0};
          cnt_d   = cnt_q - CntOne;
          // Last bit leaves this cycle: done is seen in the first idle cycle.
          if (cnt_q == CntOne) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset; a reset drops any partial word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule
